// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for fifo_stream_reader: legal read-latency bounds and stats counter width.
package fifo_stream_reader_pkg;

  localparam int unsigned RDL_MIN = 1;
  localparam int unsigned RDL_MAX = 4;
  localparam int unsigned STATS_W = 32;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// skid_ring_buffer: circular buffer with wrapping read/write pointers and an occupancy counter.
// head_o reads storage directly, so there is no path from push_data_i to head_o.
module skid_ring_buffer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SKID_DEPTH = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            push_i,
  input  logic [WIDTH-1:0]                push_data_i,
  input  logic                            pop_i,
  output logic [WIDTH-1:0]                head_o,
  output logic [$clog2(SKID_DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_i && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign occupancy_o = count_q;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  overflow_chk : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && (count_q == CNT_W'(SKID_DEPTH))))
    else $error("skid_ring_buffer: capture into full buffer");

endmodule

// File: rtl/fifo_stream_reader.sv
// Streams words out of a fixed-read-latency upstream FIFO into a valid/ready interface.
// Optional FIFO_STREAM_READER_STATS_EN adds word_count / stall_count outputs.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH             = 8,
  parameter int unsigned READ_DATA_LATENCY = 2,
  parameter int unsigned SKID_DEPTH        = READ_DATA_LATENCY + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               may_pop,
  output logic               pop,
  input  logic [WIDTH-1:0]   pop_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               idle
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [STATS_W-1:0] word_count,
  output logic [STATS_W-1:0] stall_count
`endif
);

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  if ((READ_DATA_LATENCY < RDL_MIN) || (READ_DATA_LATENCY > RDL_MAX)) begin : g_bad_latency
    $error("fifo_stream_reader: READ_DATA_LATENCY out of range");
  end
  if (SKID_DEPTH < READ_DATA_LATENCY + 1) begin : g_bad_depth
    $error("fifo_stream_reader: SKID_DEPTH must be at least READ_DATA_LATENCY+1");
  end

  logic [READ_DATA_LATENCY-1:0] sreg_q, sreg_d;
  logic                         started_q;
  logic [CNT_W-1:0]             occ;
  logic [SUM_W-1:0]             committed;
  logic                         xfer;
  logic                         capture;

  assign out_valid = (occ != '0);
  assign xfer      = out_valid && out_ready;
  assign capture   = sreg_q[READ_DATA_LATENCY-1];
  assign idle      = (sreg_q == '0) && (occ == '0);

  // Every in-flight pop already owns a slot, including the one landing this cycle.
  always_comb begin
    committed = SUM_W'(occ) - SUM_W'(xfer) + SUM_W'($countones(sreg_q));
    pop       = started_q && may_pop && (committed < SUM_W'(SKID_DEPTH));
    sreg_d    = sreg_q << 1;
    sreg_d[0] = pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      sreg_q    <= '0;
    end else begin
      started_q <= 1'b1;
      sreg_q    <= sreg_d;
    end
  end

  skid_ring_buffer #(
    .WIDTH      (WIDTH),
    .SKID_DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (capture),
    .push_data_i (pop_data),
    .pop_i       (xfer),
    .head_o      (out_data),
    .occupancy_o (occ)
  );

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [STATS_W-1:0] word_cnt_q;
  logic [STATS_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (xfer) begin
        word_cnt_q <= sat_inc(word_cnt_q);
      end
      if (out_valid && !out_ready) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
    end
  end

  assign word_count  = word_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: three instances (latency 2, 1, 4) fed by a behavioural
// upstream FIFO; delivered words are compared in order against what the upstream held.
module tb_fifo_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       may_pop   [3];
  logic       pop       [3];
  logic [7:0] pop_data  [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] out_data  [3];
  logic       idle      [3];
`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] word_count  [3];
  logic [31:0] stall_count [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    fifo_stream_reader #(
      .WIDTH             (8),
      .READ_DATA_LATENCY (LAT)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .may_pop   (may_pop[g]),
      .pop       (pop[g]),
      .pop_data  (pop_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .idle      (idle[g])
`ifdef FIFO_STREAM_READER_STATS_EN
      ,
      .word_count  (word_count[g]),
      .stall_count (stall_count[g])
`endif
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Upstream FIFO model and observation state, one set per instance.
  logic [7:0] up_mem  [3][1024];
  int         up_rd   [3];
  int         up_wr   [3];
  logic [7:0] got_mem [3][1024];
  int         got_n   [3];
  logic [7:0] pipe    [3][4];
  bit         allow   [3];
  logic       pop_s   [3];
  logic       ov_s    [3];
  logic       idle_s  [3];
  logic [7:0] od_s    [3];
  int cyc;
  int first_pop [3];
  int first_ov  [3];
  int first_x   [3];
  int last_x    [3];
  int pops      [3];
  int xfers     [3];
  int stalls    [3];
  int max_out   [3];
  int bad_pop   [3];

  function automatic int lat(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  // One clock cycle: apply inputs, sample at negedge, then advance the upstream model.
  task automatic cycle(input logic [2:0] rdy);
    for (int g = 0; g < 3; g++) begin
      out_ready[g] = rdy[g];
      may_pop[g]   = allow[g] && (up_rd[g] < up_wr[g]);
    end
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      pop_s[g]  = pop[g];
      ov_s[g]   = out_valid[g];
      od_s[g]   = out_data[g];
      idle_s[g] = idle[g];
      if (pop_s[g]) begin
        pops[g]++;
        if (first_pop[g] < 0) first_pop[g] = cyc;
      end
      if (ov_s[g] && first_ov[g] < 0) first_ov[g] = cyc;
      if (ov_s[g] && out_ready[g]) begin
        if (got_n[g] < 1024) got_mem[g][got_n[g]] = od_s[g];
        got_n[g]++;
        xfers[g]++;
        if (first_x[g] < 0) first_x[g] = cyc;
        last_x[g] = cyc;
      end
      if (ov_s[g] && !out_ready[g]) stalls[g]++;
      if (pops[g] - xfers[g] > max_out[g]) max_out[g] = pops[g] - xfers[g];
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      for (int k = 3; k > 0; k--) pipe[g][k] = pipe[g][k-1];
      if (pop_s[g] && up_rd[g] < up_wr[g]) begin
        pipe[g][0] = up_mem[g][up_rd[g]];
        up_rd[g]++;
      end else begin
        if (pop_s[g]) bad_pop[g]++;
        pipe[g][0] = 8'($urandom);
      end
      pop_data[g] = pipe[g][lat(g)-1];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc = 0;
    for (int g = 0; g < 3; g++) begin
      out_ready[g] = 1'b0;
      may_pop[g]   = 1'b0;
      allow[g]     = 1'b1;
      up_rd[g] = 0; up_wr[g] = 0; got_n[g] = 0;
      first_pop[g] = -1; first_ov[g] = -1; first_x[g] = -1; last_x[g] = -1;
      pops[g] = 0; xfers[g] = 0; stalls[g] = 0; max_out[g] = 0; bad_pop[g] = 0;
      pop_s[g] = 1'b0;
      for (int k = 0; k < 4; k++) pipe[g][k] = 8'($urandom);
      pop_data[g] = 8'($urandom);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (pop[g] !== 1'b0) begin errors++; $display("FAIL reset_pop[%0d]: got %b expected 0", g, pop[g]); end
      checks++;
      if (out_valid[g] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", g, out_valid[g]); end
      checks++;
      if (out_data[g] !== 8'h00) begin errors++; $display("FAIL reset_out_data[%0d]: got %h expected 00", g, out_data[g]); end
      checks++;
      if (idle[g] !== 1'b1) begin errors++; $display("FAIL reset_idle[%0d]: got %b expected 1", g, idle[g]); end
    end
    do_reset();
    up_mem[0][0] = 8'h11;
    up_wr[0] = 1;
    cycle(3'b111);
    checks++;
    if (pop_s[0] !== 1'b0) begin errors++; $display("FAIL first_cycle_pop: got %b expected 0", pop_s[0]); end
    cycle(3'b111);
    checks++;
    if (pop_s[0] !== 1'b1) begin errors++; $display("FAIL second_cycle_pop: got %b expected 1", pop_s[0]); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 16; i++) up_mem[g][i] = 8'(i + 1);
      up_wr[g] = 16;
    end
    for (int n = 0; n < 40; n++) cycle(3'b111);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (got_n[g] != 16) begin errors++; $display("FAIL stream_count[%0d]: got %0d expected 16", g, got_n[g]); end
      for (int i = 0; i < 16 && i < got_n[g]; i++) begin
        checks++;
        if (got_mem[g][i] !== 8'(i + 1)) begin
          errors++; $display("FAIL stream_word[%0d][%0d]: got %h expected %h", g, i, got_mem[g][i], 8'(i + 1));
        end
      end
      checks++;
      if (first_pop[g] < 0 || first_ov[g] - first_pop[g] != lat(g) + 1) begin
        errors++; $display("FAIL stream_latency[%0d]: got %0d expected %0d", g, first_ov[g] - first_pop[g], lat(g) + 1);
      end
      checks++;
      if (last_x[g] - first_x[g] != 15) begin
        errors++; $display("FAIL stream_throughput[%0d]: got span %0d expected 15", g, last_x[g] - first_x[g]);
      end
      checks++;
      if (idle_s[g] !== 1'b1) begin errors++; $display("FAIL stream_idle[%0d]: got %b expected 1", g, idle_s[g]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 16; i++) up_mem[g][i] = 8'(i + 1);
      up_wr[g] = 16;
    end
    for (int n = 0; n < 21; n++) begin
      cycle(3'b000);
      for (int g = 0; g < 3; g++) begin
        if (ov_s[g]) begin
          checks++;
          if (od_s[g] !== 8'h01) begin errors++; $display("FAIL bp_stable[%0d]: got %h expected 01", g, od_s[g]); end
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (pops[g] > lat(g) + 1) begin errors++; $display("FAIL bp_pops[%0d]: got %0d expected <= %0d", g, pops[g], lat(g) + 1); end
      checks++;
      if (ov_s[g] !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", g, ov_s[g]); end
    end
    for (int n = 0; n < 40; n++) cycle(3'b111);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (got_n[g] != 16) begin errors++; $display("FAIL bp_count[%0d]: got %0d expected 16", g, got_n[g]); end
      for (int i = 0; i < 16 && i < got_n[g]; i++) begin
        checks++;
        if (got_mem[g][i] !== 8'(i + 1)) begin
          errors++; $display("FAIL bp_word[%0d][%0d]: got %h expected %h", g, i, got_mem[g][i], 8'(i + 1));
        end
      end
      checks++;
      if (bad_pop[g] != 0) begin errors++; $display("FAIL bp_empty_pop[%0d]: got %0d expected 0", g, bad_pop[g]); end
`ifdef FIFO_STREAM_READER_STATS_EN
      checks++;
      if (word_count[g] !== 32'd16) begin errors++; $display("FAIL word_count[%0d]: got %0d expected 16", g, word_count[g]); end
      checks++;
      if (stall_count[g] !== 32'(stalls[g])) begin
        errors++; $display("FAIL stall_count[%0d]: got %0d expected %0d", g, stall_count[g], stalls[g]);
      end
`endif
    end
`ifdef FIFO_STREAM_READER_STATS_EN
    checks++;
    if (stall_count[0] < 32'd17) begin errors++; $display("FAIL stall_count_min: got %0d expected >= 17", stall_count[0]); end
`endif
  endtask

  task automatic test_empty_upstream();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    up_mem[0][0] = 8'hA5;
    up_mem[0][1] = 8'h5A;
    up_wr[0] = 2;
    allow[0] = 1'b0;
    cycle(3'b111);
    for (int k = 0; k < 4; k++) begin
      allow[0] = pat[k];
      cycle(3'b111);
    end
    allow[0] = 1'b1;
    for (int n = 0; n < 10; n++) cycle(3'b111);
    checks++;
    if (pops[0] != 2) begin errors++; $display("FAIL empty_pops: got %0d expected 2", pops[0]); end
    checks++;
    if (got_n[0] != 2) begin errors++; $display("FAIL empty_count: got %0d expected 2", got_n[0]); end
    checks++;
    if (got_mem[0][0] !== 8'hA5) begin errors++; $display("FAIL empty_word0: got %h expected a5", got_mem[0][0]); end
    checks++;
    if (got_mem[0][1] !== 8'h5A) begin errors++; $display("FAIL empty_word1: got %h expected 5a", got_mem[0][1]); end
  endtask

  task automatic test_reset_midstream();
    int nov = 0;
    do_reset();
    for (int i = 0; i < 4; i++) up_mem[2][i] = 8'(8'h21 + i);
    up_wr[2] = 4;
    for (int n = 0; n < 30 && nov < 1; n++) begin
      cycle(3'b000);
      if (ov_s[2]) nov++;
    end
    checks++;
    if (nov != 1) begin errors++; $display("FAIL mid_fill_timeout: got %0d valid cycles expected 1", nov); end
    checks++;
    if (pops[2] != 4) begin errors++; $display("FAIL mid_pops: got %0d expected 4", pops[2]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid[2] !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid[2]); end
    checks++;
    if (idle[2] !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b expected 1", idle[2]); end
    do_reset();
    for (int i = 0; i < 4; i++) up_mem[2][i] = 8'(8'h31 + i);
    up_wr[2] = 4;
    cycle(3'b111);
    checks++;
    if (pop_s[2] !== 1'b0) begin errors++; $display("FAIL mid_release_pop: got %b expected 0", pop_s[2]); end
    for (int n = 0; n < 30; n++) cycle(3'b111);
    checks++;
    if (got_n[2] != 4) begin errors++; $display("FAIL mid_after_count: got %0d expected 4", got_n[2]); end
    for (int i = 0; i < 4 && i < got_n[2]; i++) begin
      checks++;
      if (got_mem[2][i] !== 8'(8'h31 + i)) begin
        errors++; $display("FAIL mid_after_word[%0d]: got %h expected %h", i, got_mem[2][i], 8'(8'h31 + i));
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] rdy;
    bit done;
    do_reset();
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 1000; i++) up_mem[g][i] = 8'($urandom);
      up_wr[g] = 1000;
    end
    done = 1'b0;
    for (int n = 0; n < 8000 && !done; n++) begin
      for (int g = 0; g < 3; g++) allow[g] = ($urandom_range(0, 3) != 0);
      rdy = 3'($urandom);
      cycle(rdy);
      done = (got_n[0] >= 1000) && (got_n[1] >= 1000) && (got_n[2] >= 1000);
    end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (got_n[g] != 1000) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected 1000", g, got_n[g]); end
      for (int i = 0; i < 1000 && i < got_n[g]; i++) begin
        checks++;
        if (got_mem[g][i] !== up_mem[g][i]) begin
          errors++; $display("FAIL rand_word[%0d][%0d]: got %h expected %h", g, i, got_mem[g][i], up_mem[g][i]);
        end
      end
      checks++;
      if (max_out[g] > lat(g) + 1) begin
        errors++; $display("FAIL rand_occupancy[%0d]: got %0d expected <= %0d", g, max_out[g], lat(g) + 1);
      end
      checks++;
      if (bad_pop[g] != 0) begin errors++; $display("FAIL rand_empty_pop[%0d]: got %0d expected 0", g, bad_pop[g]); end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    for (int g = 0; g < 3; g++) begin
      may_pop[g]   = 1'b0;
      out_ready[g] = 1'b0;
      pop_data[g]  = 8'h00;
      allow[g]     = 1'b1;
    end
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_upstream();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
